// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate decoder with a one-entry valid/ready output register and illegal-opcode counter
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_type,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   localparam logic RV64 = (XLEN == 64);
   logic [6:0]         opc;
   logic [2:0]         type_d, type_q;
   logic               ill_d, ill_q, valid_d, valid_q, xfer;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]    imm_d, imm_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   assign opc       = inst_code[6:0];
   assign in_ready  = reset || !valid_q || out_ready;
   assign xfer      = in_valid && in_ready;
   assign out_valid = valid_q;
   assign imm_out   = imm_q;
   assign imm_type  = type_q;
   assign illegal   = ill_q;
   assign illegal_cnt = cnt_q;
   always_comb begin
      type_d = 3'd0;
      ill_d  = 1'b0;
      case (opc)
         7'b0000011, 7'b0010011, 7'b1100111: type_d = 3'd1;
         7'b0011011: begin
            type_d = RV64 ? 3'd1 : 3'd0;
            ill_d  = !RV64;
         end
         7'b0100011: type_d = 3'd2;
         7'b1100011: type_d = 3'd3;
         7'b0110111, 7'b0010111: type_d = 3'd4;
         7'b1101111: type_d = 3'd5;
         7'b0110011, 7'b0001111, 7'b1110011: type_d = 3'd0;
         7'b0111011: ill_d = !RV64;
         default: ill_d = 1'b1;
      endcase
   end
   // every format carries its sign in bit 31, so one signed widening covers RV64
   assign imm32 = (type_d == 3'd1) ? {{20{inst_code[31]}}, inst_code[31:20]} :
                  (type_d == 3'd2) ? {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]} :
                  (type_d == 3'd3) ? {{19{inst_code[31]}}, inst_code[31], inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0} :
                  (type_d == 3'd4) ? {inst_code[31:12], 12'b0} :
                  (type_d == 3'd5) ? {{11{inst_code[31]}}, inst_code[31], inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0} :
                  32'sd0;
   assign imm_d   = XLEN'(imm32);
   assign valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : valid_q);
   assign cnt_d   = (xfer && ill_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         imm_q   <= '0;
         type_q  <= 3'd0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         if (xfer) begin
            imm_q  <= imm_d;
            type_q <= type_d;
            ill_q  <= ill_d;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives three parameterisations of imm_gen_pipe with shared stimulus against a behavioural model
module tb_imm_gen_pipe;
   logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [31:0] inst_code = 0;
   logic r32, v32, il32, r64, v64, il64, r2, v2, il2;
   logic [31:0] imm32, imm2;
   logic [63:0] imm64;
   logic [2:0] t32, t64, t2;
   logic [15:0] c32, c64;
   logic [1:0] c2;
   int n_cmp = 0, n_fail = 0;
   bit m_valid;
   logic [31:0] m_imm32;
   logic [63:0] m_imm64;
   logic [2:0] m_t32, m_t64;
   logic m_il32, m_il64;
   int m_c32, m_c64, m_c2;
   logic [6:0] ops [0:13] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                              7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F};

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32),
      .inst_code(inst_code), .out_valid(v32), .out_ready(out_ready), .imm_out(imm32), .imm_type(t32),
      .illegal(il32), .illegal_cnt(c32));
   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64),
      .inst_code(inst_code), .out_valid(v64), .out_ready(out_ready), .imm_out(imm64), .imm_type(t64),
      .illegal(il64), .illegal_cnt(c64));
   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r2),
      .inst_code(inst_code), .out_valid(v2), .out_ready(out_ready), .imm_out(imm2), .imm_type(t2),
      .illegal(il2), .illegal_cnt(c2));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // immediate as a signed integer built from the field layout of each format
   function automatic void ref_dec(input logic [31:0] i, input bit x64, output logic [63:0] imm,
                                   output logic [2:0] t, output logic il);
      int s, v;
      s = int'(i);
      il = 0; t = 0; v = 0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67: t = 1;
         7'h1B: if (x64) t = 1; else il = 1;
         7'h23: t = 2;
         7'h63: t = 3;
         7'h37, 7'h17: t = 4;
         7'h6F: t = 5;
         7'h33, 7'h0F, 7'h73: t = 0;
         7'h3B: il = !x64;
         default: il = 1;
      endcase
      case (t)
         1: v = s >>> 20;
         2: v = ((s >>> 25) <<< 5) | int'(i[11:7]);
         3: v = ((s >>> 31) <<< 12) | (int'(i[7]) <<< 11) | (int'(i[30:25]) <<< 5) | (int'(i[11:8]) <<< 1);
         4: v = s & 32'hFFFFF000;
         5: v = ((s >>> 31) <<< 20) | (int'(i[19:12]) <<< 12) | (int'(i[20]) <<< 11) | (int'(i[30:21]) <<< 1);
         default: v = 0;
      endcase
      imm = 64'(longint'(v));
   endfunction

   task automatic tick();
      logic [63:0] e;
      logic [2:0] t;
      logic il;
      bit rdy;
      rdy = reset || !m_valid || out_ready;
      if (reset) begin
         m_valid = 0; m_imm32 = 0; m_imm64 = 0; m_t32 = 0; m_t64 = 0;
         m_il32 = 0; m_il64 = 0; m_c32 = 0; m_c64 = 0; m_c2 = 0;
      end else if (in_valid && rdy) begin
         m_valid = 1;
         ref_dec(inst_code, 0, e, t, il);
         m_imm32 = e[31:0]; m_t32 = t; m_il32 = il;
         if (il && m_c32 < 65535) m_c32++;
         if (il && m_c2 < 3) m_c2++;
         ref_dec(inst_code, 1, e, t, il);
         m_imm64 = e; m_t64 = t; m_il64 = il;
         if (il && m_c64 < 65535) m_c64++;
      end else if (out_ready) m_valid = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; in_valid = 0; out_ready = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 1; inst_code = 32'h7F; out_ready = 0;
      #1;
      n_cmp++;
      if ({r32, r64, r2} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {r32, r64, r2}); end
      tick();
      n_cmp++;
      if ({v32, imm32, t32, il32, c32} !== 53'd0) begin n_fail++; $display("FAIL reset_u32: got %b %h %0d %b %0d want all 0", v32, imm32, t32, il32, c32); end
      n_cmp++;
      if ({v64, imm64, t64, il64, c64} !== 85'd0) begin n_fail++; $display("FAIL reset_u64: got %b %h %0d %b %0d want all 0", v64, imm64, t64, il64, c64); end
      n_cmp++;
      if ({v2, c2} !== 3'd0) begin n_fail++; $display("FAIL reset_u2: got %b %0d want 0 0", v2, c2); end
      reset = 0; in_valid = 0;
      #1;
      n_cmp++;
      if (r32 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", r32); end
   endtask

   task automatic test_addi();
      in_valid = 1; inst_code = 32'hFFF00093; out_ready = 1;
      tick();
      in_valid = 0;
      n_cmp++;
      if ({v32, imm32, t32, il32} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin n_fail++; $display("FAIL addi: got %b %h %0d %b want 1 ffffffff 1 0", v32, imm32, t32, il32); end
      tick();
      n_cmp++;
      if (v32 !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", v32); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1; inst_code = 32'hFE112E23; out_ready = 1;
      tick();
      inst_code = 32'hFF9FF06F;
      n_cmp++;
      if ({v32, imm32, t32} !== {1'b1, 32'hFFFFFFFC, 3'd2}) begin n_fail++; $display("FAIL b2b_sw: got %b %h %0d want 1 fffffffc 2", v32, imm32, t32); end
      tick();
      in_valid = 0;
      n_cmp++;
      if ({v32, imm32, t32} !== {1'b1, 32'hFFFFFFF8, 3'd5}) begin n_fail++; $display("FAIL b2b_jal: got %b %h %0d want 1 fffffff8 5", v32, imm32, t32); end
      tick();
   endtask

   task automatic test_rv64();
      in_valid = 1; inst_code = 32'h800002B7; out_ready = 1;
      tick();
      inst_code = 32'h00000033;
      n_cmp++;
      if ({v64, imm64, t64, il64} !== {1'b1, 64'hFFFFFFFF80000000, 3'd4, 1'b0}) begin n_fail++; $display("FAIL lui64: got %b %h %0d %b want 1 ffffffff80000000 4 0", v64, imm64, t64, il64); end
      n_cmp++;
      if ({imm32, t32} !== {32'h80000000, 3'd4}) begin n_fail++; $display("FAIL lui32: got %h %0d want 80000000 4", imm32, t32); end
      tick();
      inst_code = 32'h0000003B;
      n_cmp++;
      if ({v64, imm64, t64, il64} !== {1'b1, 64'h0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL add64: got %b %h %0d %b want 1 0 0 0", v64, imm64, t64, il64); end
      tick();
      in_valid = 0;
      n_cmp++;
      if ({il64, il32} !== 2'b01) begin n_fail++; $display("FAIL addw_legality: got il64=%b il32=%b want 0 1", il64, il32); end
      tick();
   endtask

   task automatic test_backpressure();
      in_valid = 1; inst_code = 32'h00500113; out_ready = 0;
      tick();
      inst_code = 32'h0000007F;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (r32 !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", k, r32); end
         tick();
         n_cmp++;
         if ({v32, imm32, t32, il32, c32} !== {1'b1, 32'd5, 3'd1, 1'b0, 16'(m_c32)}) begin n_fail++; $display("FAIL bp_hold%0d: got %b %h %0d %b %0d want 1 5 1 0 %0d", k, v32, imm32, t32, il32, c32, m_c32); end
      end
      out_ready = 1;
      #1;
      n_cmp++;
      if (r32 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", r32); end
      tick();
      in_valid = 0;
      n_cmp++;
      if ({v32, imm32, t32, il32, c32} !== {1'b1, 32'd0, 3'd0, 1'b1, 16'(m_c32)}) begin n_fail++; $display("FAIL bp_next: got %b %h %0d %b %0d want 1 0 0 1 %0d", v32, imm32, t32, il32, c32, m_c32); end
      tick();
   endtask

   task automatic test_saturate();
      do_reset();
      out_ready = 1; in_valid = 1; inst_code = 32'h0000007F;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if ({v2, il2, imm2, c2} !== {1'b1, 1'b1, 32'd0, (k < 2) ? 2'(k + 1) : 2'd3}) begin n_fail++; $display("FAIL sat%0d: got %b %b %h %0d want 1 1 0 %0d", k, v2, il2, imm2, c2, (k < 2) ? k + 1 : 3); end
      end
      in_valid = 0;
      tick();
   endtask

   task automatic test_reset_midflight();
      out_ready = 0; in_valid = 1; inst_code = 32'h0000007F;
      tick();
      #1;
      n_cmp++;
      if ({v32, r32} !== 2'b10) begin n_fail++; $display("FAIL mid_stall: got valid=%b ready=%b want 1 0", v32, r32); end
      reset = 1;
      #1;
      n_cmp++;
      if (r32 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", r32); end
      tick();
      reset = 0; in_valid = 0;
      #1;
      n_cmp++;
      if ({v32, c32, r32} !== {1'b0, 16'd0, 1'b1}) begin n_fail++; $display("FAIL mid_after: got %b %0d %b want 0 0 1", v32, c32, r32); end
      in_valid = 1; inst_code = 32'hFFF00093; out_ready = 1;
      tick();
      in_valid = 0;
      n_cmp++;
      if ({v32, imm32} !== {1'b1, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL mid_first: got %b %h want 1 ffffffff", v32, imm32); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] w;
      bit rdy;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         w = $urandom();
         if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 13)];
         inst_code = w;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         rdy = !m_valid || out_ready;
         n_cmp++;
         if ({r32, r64, r2} !== {3{rdy}}) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", n, {r32, r64, r2}, {3{rdy}}); end
         tick();
         n_cmp++;
         if ({v32, v64, v2} !== {3{m_valid}}) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", n, {v32, v64, v2}, {3{m_valid}}); end
         if (m_valid) begin
            n_cmp++;
            if ({imm32, t32, il32} !== {m_imm32, m_t32, m_il32} || {imm2, t2, il2} !== {m_imm32, m_t32, m_il32}) begin n_fail++; $display("FAIL rnd_d32@%0d: got %h %0d %b want %h %0d %b", n, imm32, t32, il32, m_imm32, m_t32, m_il32); end
            n_cmp++;
            if ({imm64, t64, il64} !== {m_imm64, m_t64, m_il64}) begin n_fail++; $display("FAIL rnd_d64@%0d: got %h %0d %b want %h %0d %b", n, imm64, t64, il64, m_imm64, m_t64, m_il64); end
         end
         n_cmp++;
         if ({c32, c64, c2} !== {16'(m_c32), 16'(m_c64), 2'(m_c2)}) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d %0d %0d want %0d %0d %0d", n, c32, c64, c2, m_c32, m_c64, m_c2); end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_rv64();
      test_backpressure();
      test_saturate();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width of the immediate; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the illegal-opcode counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  inst_code is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts inst_code this cycle.
REQ-007 SHALL have port inst_code  input  32  RV32/RV64 instruction word.
REQ-008 SHALL have port out_valid  output  1  imm_out, imm_type and illegal hold a result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 SHALL have port imm_out  output  XLEN  sign-extended immediate.
REQ-011 SHALL have port imm_type  output  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-012 SHALL have port illegal  output  1  opcode not recognised.
REQ-013 SHALL have port illegal_cnt  output  CNT_W  count of accepted illegal opcodes.

Function
REQ-014 SHALL decode inst_code[6:0] as follows: 0000011, 0010011, 1100111 and 0011011 (XLEN=64 only) as I; 0100011 as S; 1100011 as B; 0110111 and 0010111 as U; 1101111 as J; 0110011, 0111011 (XLEN=64 only), 0001111 and 1110011 as NONE; every other opcode as illegal.
REQ-015 SHALL form the immediate as follows: I={i[31:20]}; S={i[31:25],i[11:7]}; B={i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'b0}; J={i[31],i[19:12],i[20],i[30:21],0}.
REQ-016 SHALL sign-extend every immediate from inst_code[31] to XLEN bits, including U-type at XLEN=64.
REQ-017 SHALL output imm_out=0 for NONE and illegal.
REQ-018 SHALL output illegal=1 and imm_type=0 for illegal opcodes.
REQ-019 SHALL use a one-entry output register; a transfer occurs when in_valid and in_ready are both 1.
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-021 SHALL present the result of an accepted instruction on the cycle after the transfer (latency 1) with out_valid=1.
REQ-022 SHALL hold imm_out, imm_type and illegal stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept a new instruction and load its result when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, sustaining 1 result per cycle with no bubble.
REQ-024 SHALL clear out_valid on the cycle after out_ready=1 when in_valid=0.
REQ-025 SHALL increment illegal_cnt by 1 on each accepted illegal instruction, at the transfer edge.
REQ-026 SHALL saturate illegal_cnt at all-ones with no wrap.
REQ-027 SHALL leave illegal_cnt unchanged for illegal inst_code presented while in_ready=0.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, set out_valid=0, imm_out=0, imm_type=0, illegal=0 and illegal_cnt=0.
REQ-029 SHALL give reset priority over a simultaneous transfer, discarding any pending result.
REQ-030 SHALL drive in_ready=1 during reset and in the first cycle after reset.
REQ-031 SHALL require no extra cycles after reset deasserts before accepting the first instruction.

Verification
REQ-032 SHALL show: XLEN=32, inst 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm_out=0xFFFFFFFF, imm_type=1.
REQ-033 SHALL show: back-to-back 0xFE112E23 (sw x1,-4(x2)) then 0xFF9FF06F (jal x0,-8), out_ready=1 -> 0xFFFFFFFC type 2, then 0xFFFFFFF8 type 5, on consecutive cycles.
REQ-034 SHALL show: XLEN=64, inst 0x800002B7 (lui x5,0x80000) -> imm_out=0xFFFFFFFF80000000, imm_type=4; inst 0x00000033 -> imm_out=0, imm_type=0, illegal=0.
REQ-035 SHALL show: backpressure with out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 and outputs unchanged; out_ready=1 -> next queued result appears the following cycle.
REQ-036 SHALL show: CNT_W=2, five accepted 0x0000007F -> illegal=1, imm_out=0 each, and illegal_cnt = 1, 2, 3, 3, 3.
REQ-037 SHALL show: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, illegal_cnt=0, in_ready=1.
